vec_cache_us_rsp_egress: RTL and testbench

- Downstream of the read-data-buffer agent; takes each full cache line it emits (data, txn_id, rob_entry_id, sideband) toward the upstream (US) requester.
- The agent cannot stall once a line is produced, so this block absorbs lines in a small FIFO.
- Each line is serialised into BEAT_WIDTH beats under a valid/ready handshake.
- in_rdy is advertised back so the agent gates new dataram reads.

---
 rtl/vec_cache_us_rsp_egress.sv | 133 +++++++++++++
 tb/tb_vec_cache_us_rsp_egress.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_us_rsp_egress.sv
// Upstream response egress: buffers full cache lines from the read-data-buffer agent
// and serialises each one into BEAT_WIDTH beats under a valid/ready handshake.
module vec_cache_us_rsp_egress #(
    parameter int DATA_WIDTH   = 1024,
    parameter int BEAT_WIDTH   = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int RDY_MARGIN   = 2,
    parameter int TXN_ID_WIDTH = 8,
    parameter int ROB_ID_WIDTH = 5,
    parameter int SB_WIDTH     = 16,
    localparam int BEATS  = DATA_WIDTH / BEAT_WIDTH,
    localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [TXN_ID_WIDTH-1:0] in_txn_id,
    input  logic [ROB_ID_WIDTH-1:0] in_rob_id,
    input  logic [SB_WIDTH-1:0]     in_sideband,
    output logic                    in_rdy,
    output logic                    us_vld,
    input  logic                    us_rdy,
    output logic [BEAT_WIDTH-1:0]   us_data,
    output logic [BIDX_W-1:0]       us_beat_idx,
    output logic                    us_last,
    output logic [TXN_ID_WIDTH-1:0] us_txn_id,
    output logic [ROB_ID_WIDTH-1:0] us_rob_id,
    output logic [SB_WIDTH-1:0]     us_sideband,
    output logic [CNT_W-1:0]        fifo_cnt,
    output logic                    overflow_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [BEATS-1:0][BEAT_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [TXN_ID_WIDTH-1:0]          r_txn_mem  [FIFO_DEPTH];
    logic [ROB_ID_WIDTH-1:0]          r_rob_mem  [FIFO_DEPTH];
    logic [SB_WIDTH-1:0]              r_sb_mem   [FIFO_DEPTH];

    logic [0:0]        r_state;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIDX_W-1:0] r_beat_idx;
    logic              r_ovf;

    logic              w_fire;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [0:0]        w_state_nxt;

    assign w_fire = us_vld && us_rdy;
    assign w_pop  = w_fire && us_last;
    assign w_full = (r_cnt == FULL_CNT);
    // A full FIFO still takes a line when the head retires on the same edge.
    assign w_push = in_vld && (!w_full || w_pop);
    assign w_drop = in_vld && w_full && !w_pop;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cnt_nxt != '0) w_state_nxt = S_SEND;
            S_SEND:  if (w_pop && (w_cnt_nxt == '0)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: line storage has no reset; the count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= in_data;
            r_txn_mem[r_wr_ptr]  <= in_txn_id;
            r_rob_mem[r_wr_ptr]  <= in_rob_id;
            r_sb_mem[r_wr_ptr]   <= in_sideband;
        end
    end

    // NOTE: non-blocking assignments keep every register update reading pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_beat_idx <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_drop) r_ovf <= 1'b1;
            if ((r_state == S_SEND) && w_fire) begin
                if (us_last) begin
                    r_beat_idx <= '0;
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                end else begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                end
            end
        end
    end

    assign us_vld       = (r_cnt != '0);
    assign us_last      = us_vld && (r_beat_idx == LAST_BEAT);
    assign us_data      = r_data_mem[r_rd_ptr][r_beat_idx];
    assign us_beat_idx  = r_beat_idx;
    assign us_txn_id    = r_txn_mem[r_rd_ptr];
    assign us_rob_id    = r_rob_mem[r_rd_ptr];
    assign us_sideband  = r_sb_mem[r_rd_ptr];
    assign fifo_cnt     = r_cnt;
    assign overflow_err = r_ovf;
    assign in_rdy       = (FIFO_DEPTH - int'(r_cnt)) >= RDY_MARGIN;

endmodule

// File: tb/tb_vec_cache_us_rsp_egress.sv
// Directed bench for vec_cache_us_rsp_egress: a vector table for the single-line case
// plus hand sequences for back-pressure, fill/overflow, full push+pop, wrap and reset.
module tb_vec_cache_us_rsp_egress;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_vld = 1'b0;
    logic [1023:0]  in_data = '0;
    logic [7:0]     in_txn_id = '0;
    logic [4:0]     in_rob_id = '0;
    logic [15:0]    in_sideband = '0;
    logic           in_rdy;
    logic           us_vld;
    logic           us_rdy = 1'b0;
    logic [255:0]   us_data;
    logic [1:0]     us_beat_idx;
    logic           us_last;
    logic [7:0]     us_txn_id;
    logic [4:0]     us_rob_id;
    logic [15:0]    us_sideband;
    logic [2:0]     fifo_cnt;
    logic           overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    vec_cache_us_rsp_egress dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_data(in_data), .in_txn_id(in_txn_id),
        .in_rob_id(in_rob_id), .in_sideband(in_sideband), .in_rdy(in_rdy),
        .us_vld(us_vld), .us_rdy(us_rdy), .us_data(us_data),
        .us_beat_idx(us_beat_idx), .us_last(us_last), .us_txn_id(us_txn_id),
        .us_rob_id(us_rob_id), .us_sideband(us_sideband),
        .fifo_cnt(fifo_cnt), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           vld;
        logic [1023:0]  data;
        logic [7:0]     txn;
        logic           rdy;
        logic           e_vld;
        logic           e_last;
        logic [1:0]     e_idx;
        logic [255:0]   e_data;
        logic [7:0]     e_txn;
        logic [2:0]     e_cnt;
        logic           e_in_rdy;
        logic           e_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] beat_val(input int tag, input int b);
        return 256'((tag << 8) | b);
    endfunction

    function automatic logic [1023:0] mk_line(input int tag);
        logic [1023:0] l;
        for (int b = 0; b < 4; b++) l[b*256 +: 256] = beat_val(tag, b);
        return l;
    endfunction

    task automatic drive_line(input int tag);
        in_vld      = 1'b1;
        in_data     = mk_line(tag);
        in_txn_id   = 8'(tag);
        in_rob_id   = 5'(tag);
        in_sideband = 16'(tag);
    endtask

    task automatic push_line(input int tag);
        drive_line(tag);
        tick();
        in_vld = 1'b0;
    endtask

    task automatic do_reset();
        in_vld = 1'b0;
        us_rdy = 1'b0;
        rst    = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Pushes tags first_tag.. (honouring in_rdy) while draining; expects lines exp_first.. in order.
    task automatic stream(input int first_tag, input int n_push, input int exp_first,
                          input int n_exp, input bit rand_rdy);
        int pushed = 0;
        int line   = 0;
        int beat   = 0;
        int beats  = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_vld = 1'b0;
            if (pushed < n_push && in_rdy) begin
                drive_line(first_tag + pushed);
                pushed++;
            end
            us_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (us_vld && us_rdy) begin
                check("stream data", us_data, beat_val(exp_first + line, beat));
                check("stream idx", 256'(us_beat_idx), 256'(beat));
                check("stream last", 256'(us_last), 256'(beat == 3));
                check("stream rob", 256'(us_rob_id), 256'(5'(exp_first + line)));
                beats++;
                beat++;
                if (beat == 4) begin
                    beat = 0;
                    line++;
                end
            end
            if (pushed == n_push && line == n_exp) break;
            tick();
        end
        in_vld = 1'b0;
        tick();
        check("stream beat total", 256'(beats), 256'(4 * n_exp));
        check("stream final cnt", 256'(fifo_cnt), 256'(0));
        check("stream final vld", 256'(us_vld), 256'(0));
    endtask

    initial begin
        vecs[0] = '{1'b1, {256'hD, 256'hC, 256'hB, 256'hA}, 8'h11, 1'b1,
                    1'b0, 1'b0, 2'd0, 256'h0, 8'h00, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, '0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 256'hA, 8'h11, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, '0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 256'hB, 8'h11, 3'd1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, '0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd2, 256'hC, 8'h11, 3'd1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, '0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd3, 256'hD, 8'h11, 3'd1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 256'h0, 8'h00, 3'd0, 1'b1, 1'b0};

        do_reset();

        // Single line, table driven: row inputs apply to the next edge, expectations are the current state.
        for (int i = 0; i < 6; i++) begin
            in_vld    = vecs[i].vld;
            in_data   = vecs[i].data;
            in_txn_id = vecs[i].txn;
            us_rdy    = vecs[i].rdy;
            check($sformatf("vec%0d us_vld", i), 256'(us_vld), 256'(vecs[i].e_vld));
            check($sformatf("vec%0d us_last", i), 256'(us_last), 256'(vecs[i].e_last));
            check($sformatf("vec%0d beat_idx", i), 256'(us_beat_idx), 256'(vecs[i].e_idx));
            check($sformatf("vec%0d fifo_cnt", i), 256'(fifo_cnt), 256'(vecs[i].e_cnt));
            check($sformatf("vec%0d in_rdy", i), 256'(in_rdy), 256'(vecs[i].e_in_rdy));
            check($sformatf("vec%0d overflow", i), 256'(overflow_err), 256'(vecs[i].e_ovf));
            if (vecs[i].e_vld) begin
                check($sformatf("vec%0d us_data", i), us_data, vecs[i].e_data);
                check($sformatf("vec%0d txn", i), 256'(us_txn_id), 256'(vecs[i].e_txn));
            end
            tick();
        end
        in_vld = 1'b0;

        // Back-pressure at beat 1.
        us_rdy = 1'b1;
        push_line(2);
        check("bp beat0 data", us_data, beat_val(2, 0));
        tick();
        us_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp held idx", 256'(us_beat_idx), 256'(1));
            check("bp held data", us_data, beat_val(2, 1));
            check("bp held txn", 256'(us_txn_id), 256'(8'd2));
            check("bp held sb", 256'(us_sideband), 256'(16'd2));
            check("bp held vld", 256'(us_vld), 256'(1));
        end
        us_rdy = 1'b1;
        tick();
        check("bp beat2 data", us_data, beat_val(2, 2));
        tick();
        check("bp beat3 data", us_data, beat_val(2, 3));
        check("bp beat3 last", 256'(us_last), 256'(1));
        tick();
        check("bp drained vld", 256'(us_vld), 256'(0));

        // Fill and overflow.
        us_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_line(10 + i);
            check("fill cnt", 256'(fifo_cnt), 256'(i + 1));
            check("fill in_rdy", 256'(in_rdy), 256'(i + 1 < 3));
        end
        check("fill no overflow", 256'(overflow_err), 256'(0));
        push_line(99);
        check("ovf flag", 256'(overflow_err), 256'(1));
        check("ovf cnt held", 256'(fifo_cnt), 256'(4));
        check("ovf head intact", us_data, beat_val(10, 0));
        tick();
        check("ovf sticky", 256'(overflow_err), 256'(1));

        // Full FIFO: push lands on the same edge as the head's last beat.
        do_reset();
        check("reset ovf clear", 256'(overflow_err), 256'(0));
        for (int i = 0; i < 4; i++) push_line(10 + i);
        check("full cnt", 256'(fifo_cnt), 256'(4));
        us_rdy = 1'b1;
        repeat (3) tick();
        check("full at last", 256'(us_last), 256'(1));
        drive_line(14);
        tick();
        in_vld = 1'b0;
        us_rdy = 1'b0;
        check("full push+pop cnt", 256'(fifo_cnt), 256'(4));
        check("full push+pop ovf", 256'(overflow_err), 256'(0));
        check("full next head", us_data, beat_val(11, 0));
        check("full next idx", 256'(us_beat_idx), 256'(0));
        stream(0, 0, 11, 4, 1'b0);

        // Pointer wrap with random back-pressure.
        do_reset();
        stream(0, 10, 0, 10, 1'b1);

        // Reset in the middle of a line.
        do_reset();
        us_rdy = 1'b0;
        push_line(20);
        push_line(21);
        us_rdy = 1'b1;
        tick();
        tick();
        check("mid beat idx", 256'(us_beat_idx), 256'(2));
        rst = 1'b1;
        #1;
        check("rst us_vld", 256'(us_vld), 256'(0));
        check("rst cnt", 256'(fifo_cnt), 256'(0));
        check("rst idx", 256'(us_beat_idx), 256'(0));
        check("rst in_rdy", 256'(in_rdy), 256'(1));
        check("rst last", 256'(us_last), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post rst idle", 256'(us_vld), 256'(0));
        end
        push_line(22);
        check("post rst vld", 256'(us_vld), 256'(1));
        check("post rst idx", 256'(us_beat_idx), 256'(0));
        check("post rst data", us_data, beat_val(22, 0));
        check("post rst cnt", 256'(fifo_cnt), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
